// File: rtl/osc_pkg.sv
// Shared constants and config record for the programmable oscillator bank.
// Reset config (2/1) makes an enabled channel run at clk/2 with 50% duty.
package osc_pkg;
   localparam int DEF_CNT_W  = 16;
   localparam int MIN_PERIOD = 2;
   localparam int RST_PERIOD = 2;
   localparam int RST_HIGH   = 1;

   typedef struct packed {
      logic [DEF_CNT_W-1:0] period;
      logic [DEF_CNT_W-1:0] high;
   } osc_cfg_t;
endpackage

// File: rtl/osc_channel.sv
// One oscillator channel: shadow/active config, phase counter, registered out and tick.
// Active config only changes at a period start or while disabled, so out never glitches mid-period.
module osc_channel
   import osc_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             sync,
   input  logic             wr,
   input  logic [CNT_W-1:0] wr_period,
   input  logic [CNT_W-1:0] wr_high,
   output logic             out,
   output logic             tick
);
   // Same layout as osc_cfg_t, sized by this instance's CNT_W.
   typedef struct packed {
      logic [CNT_W-1:0] period;
      logic [CNT_W-1:0] high;
   } cfg_t;

   cfg_t             shadow, active, shadow_nxt, active_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt, eff_period;
   logic             was_en, start;

   always_comb begin
      shadow_nxt = wr ? cfg_t'{period: wr_period, high: wr_high} : shadow;
      eff_period = (active.period < CNT_W'(MIN_PERIOD)) ? CNT_W'(MIN_PERIOD) : active.period;
      start      = !was_en || sync || (cnt == eff_period - 1'b1);
      // A same-edge write bypasses straight into active at a period start.
      active_nxt = (!en || start) ? shadow_nxt : active;
      cnt_nxt    = start ? '0 : cnt + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow <= cfg_t'{period: CNT_W'(RST_PERIOD), high: CNT_W'(RST_HIGH)};
         active <= cfg_t'{period: CNT_W'(RST_PERIOD), high: CNT_W'(RST_HIGH)};
         cnt    <= '0;
         out    <= 1'b0;
         tick   <= 1'b0;
         was_en <= 1'b0;
      end else begin
         shadow <= shadow_nxt;
         active <= active_nxt;
         was_en <= en;
         if (!en) begin
            cnt  <= '0;
            out  <= 1'b0;
            tick <= 1'b0;
         end else begin
            cnt  <= cnt_nxt;
            out  <= (cnt_nxt < active_nxt.high);
            tick <= (cnt_nxt == '0);
         end
      end
   end
endmodule

// File: rtl/prog_osc_bank.sv
// Bank of independent programmable oscillators with double-buffered period/high config.
// Out-of-range cfg_ch values match no channel and are dropped.
module prog_osc_bank
   import osc_pkg::*;
#(
   parameter  int CHANNELS = 4,
   parameter  int CNT_W    = DEF_CNT_W,
   localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CHANNELS-1:0] en,
   input  logic                sync,
   input  logic                cfg_wr,
   input  logic [CH_W-1:0]     cfg_ch,
   input  logic [CNT_W-1:0]    cfg_period,
   input  logic [CNT_W-1:0]    cfg_high,
   output logic [CHANNELS-1:0] out,
   output logic [CHANNELS-1:0] tick
);
   logic [CHANNELS-1:0] wr;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      assign wr[i] = cfg_wr && (cfg_ch == CH_W'(i));

      osc_channel #(.CNT_W(CNT_W)) u_ch (
         .clk       (clk),
         .rst       (rst),
         .en        (en[i]),
         .sync      (sync),
         .wr        (wr[i]),
         .wr_period (cfg_period),
         .wr_high   (cfg_high),
         .out       (out[i]),
         .tick      (tick[i])
      );
   end
endmodule

// File: tb/tb_prog_osc_bank.sv
// Directed bench for prog_osc_bank: phase/config model checked every cycle plus literal waveform checks.
// Five channels are built so that cfg_ch=5 is a representable but out-of-range address.
module tb_prog_osc_bank;
   localparam int NCH = 5;
   localparam int CW  = 16;

   logic           clk = 1'b0;
   logic           rst;
   logic [NCH-1:0] en;
   logic           sync;
   logic           cfg_wr;
   logic [2:0]     cfg_ch;
   logic [CW-1:0]  cfg_period, cfg_high;
   logic [NCH-1:0] out, tick;

   int n_chk  = 0;
   int n_fail = 0;
   bit checking = 1'b0;

   prog_osc_bank #(.CHANNELS(NCH), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .en(en), .sync(sync), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch),
      .cfg_period(cfg_period), .cfg_high(cfg_high), .out(out), .tick(tick)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: each channel is a phase position within its current period; the
   // waveform is simply "phase < high", with tick marking phase 0.
   int sh_p[NCH], sh_h[NCH], ac_p[NCH], ac_h[NCH], ph[NCH];
   bit running[NCH];
   logic [NCH-1:0] m_out, m_tick;

   function automatic int eff(input int p);
      return (p < 2) ? 2 : p;
   endfunction

   initial begin
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            for (int i = 0; i < NCH; i++) begin
               sh_p[i] = 2; sh_h[i] = 1; ac_p[i] = 2; ac_h[i] = 1; ph[i] = 0; running[i] = 0;
            end
            m_out = '0; m_tick = '0;
         end else begin
            for (int i = 0; i < NCH; i++) begin
               if (cfg_wr && int'(cfg_ch) == i) begin
                  sh_p[i] = int'(cfg_period); sh_h[i] = int'(cfg_high);
               end
               if (!en[i]) begin
                  ac_p[i] = sh_p[i]; ac_h[i] = sh_h[i];
                  ph[i] = 0; running[i] = 0; m_out[i] = 0; m_tick[i] = 0;
               end else begin
                  if (!running[i] || sync || ph[i] == eff(ac_p[i]) - 1) begin
                     ph[i] = 0; ac_p[i] = sh_p[i]; ac_h[i] = sh_h[i];
                  end else begin
                     ph[i]++;
                  end
                  running[i] = 1;
                  m_out[i]  = (ph[i] < ac_h[i]);
                  m_tick[i] = (ph[i] == 0);
               end
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (checking && !rst) begin
            chk("model_out", 32'(out), 32'(m_out));
            chk("model_tick", 32'(tick), 32'(m_tick));
         end
      end
   end

   task automatic wr_cfg(input int ch, input int p, input int h);
      cfg_wr = 1'b1; cfg_ch = 3'(ch); cfg_period = CW'(p); cfg_high = CW'(h);
      @(negedge clk);
      cfg_wr = 1'b0;
   endtask

   initial begin
      rst = 1'b1; en = '0; sync = 1'b0; cfg_wr = 1'b0; cfg_ch = '0;
      cfg_period = '0; cfg_high = '0;
      repeat (3) @(negedge clk);
      chk("reset_out", 32'(out), 0);
      chk("reset_tick", 32'(tick), 0);
      rst = 1'b0;
      checking = 1'b1;
      @(negedge clk);
      chk("idle_out", 32'(out), 0);

      // Defaults on ch0: clk/2, 50% duty, tick every 2nd cycle.
      en = 5'b00001;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("t1_out0", 32'(out[0]), 32'(k % 2 == 0));
         chk("t1_tick0", 32'(tick[0]), 32'(k % 2 == 0));
         chk("t1_others", 32'(out[4:1]), 0);
      end

      // ch1 period 5 high 2: 1,1,0,0,0.
      wr_cfg(1, 5, 2);
      en[1] = 1'b1;
      for (int k = 0; k < 13; k++) begin
         @(negedge clk);
         chk("t2_out1", 32'(out[1]), 32'(k % 5 < 2));
         chk("t2_tick1", 32'(tick[1]), 32'(k % 5 == 0));
      end

      // Mid-period rewrite at cnt=2: finish 0,0 then 1,0,0 repeating.
      cfg_wr = 1'b1; cfg_ch = 3'd1; cfg_period = 16'd3; cfg_high = 16'd1;
      for (int k = 0; k < 9; k++) begin
         @(negedge clk);
         cfg_wr = 1'b0;
         chk("t3_out1", 32'(out[1]), 32'(k >= 2 && (k - 2) % 3 == 0));
         chk("t3_tick1", 32'(tick[1]), 32'(k >= 2 && (k - 2) % 3 == 0));
      end

      // Boundaries: period 0 acts as 2, high >= period holds 1, bad channel ignored.
      wr_cfg(2, 0, 1);
      wr_cfg(3, 4, 7);
      wr_cfg(5, 9, 9);
      en[3:2] = 2'b11;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("t4_out2_p0", 32'(out[2]), 32'(k % 2 == 0));
         chk("t4_out3_hi", 32'(out[3]), 1);
         chk("t4_tick3", 32'(tick[3]), 32'(k % 4 == 0));
         chk("t4_ch4_idle", 32'({out[4], tick[4]}), 0);
      end
      wr_cfg(2, 3, 0);
      repeat (3) @(negedge clk);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("t4_out2_h0", 32'(out[2]), 0);
      end

      // sync: all enabled channels restart together; ch4 stays off.
      sync = 1'b1;
      @(negedge clk);
      sync = 1'b0;
      chk("t5_tick_all", 32'(tick[3:0]), 32'hF);
      chk("t5_out_ph0", 32'(out[3:0]), 32'hB);
      chk("t5_ch4", 32'({out[4], tick[4]}), 0);
      @(negedge clk);
      chk("t5_tick_ph1", 32'(tick[3:0]), 0);
      chk("t5_out_ph1", 32'(out[3:0]), 32'h8);

      // Async reset between edges, then clk/2 everywhere from reset config.
      #2 rst = 1'b1;
      #1;
      chk("t6_rst_out", 32'(out), 0);
      chk("t6_rst_tick", 32'(tick), 0);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("t6_out", 32'(out[3:0]), (k % 2 == 0) ? 32'hF : 32'h0);
         chk("t6_tick", 32'(tick[3:0]), (k % 2 == 0) ? 32'hF : 32'h0);
      end

      checking = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
